rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Reset sequencer between the clock wizard and the rocket TestHarness on FPGA builds. Runs on the free-running board clock, drives the wizard's active-low reset, and qualifies its lock output with a synchronizer and stability window. Releases the system reset only after lock has held for a programmable number of cycles. On lock loss while running, it re-asserts system reset and restarts the wizard.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before reset release begins
- RST_HOLD_CYCLES, 16: extra cycles sys_reset stays high after lock is stable
- WIZ_RST_CYCLES, 8: cycles wiz_resetn is held low per wizard restart
- LOCK_TIMEOUT_CYCLES, 65536: wait-for-lock limit (timeout build only)
- clock  input  1  free-running board clock, never the wizard output
- reset  input  1  synchronous, active-high block reset
- locked_in  input  1  wizard lock status, asynchronous to clock
- soft_rst_req  input  1  single-cycle request to reset the system without restarting the wizard
- wiz_resetn  output  1  active-low reset to clock wizard
- sys_reset  output  1  active-high reset to TestHarness
- ready  output  1  high exactly while in RUN
- relock_count  output  8  saturating count of lock losses seen in RUN
- lock_timeout  output  1  sticky; set on wait-for-lock timeout

## Operation
- locked_in passes through a 2-flop synchronizer, giving locked_s. No logic samples locked_in directly.
- FSM states: WIZ_RST, WAIT_LOCK, STABLE, HOLD, RUN. One shared down-counter, reloaded on every state entry.
- WIZ_RST:
  - wiz_resetn=0 for exactly WIZ_RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 goes to STABLE.
  - Timeout build: if the counter reaches 0 first, set lock_timeout and go to WIZ_RST.
- STABLE:
  - locked_s=0 on any cycle returns to WAIT_LOCK with the counter reloaded. There is no partial credit.
  - After LOCK_STABLE_CYCLES consecutive locked_s=1 cycles, go to HOLD.
- HOLD:
  - Runs RST_HOLD_CYCLES, then goes to RUN.
  - locked_s=0 during HOLD goes to WIZ_RST. relock_count is not incremented.
- RUN:
  - locked_s=0 goes to WIZ_RST and increments relock_count, saturating at 255.
  - Otherwise soft_rst_req=1 goes to HOLD.
  - If both occur in the same cycle, lock loss wins.
- soft_rst_req outside RUN is ignored.
- Output decode:
  - sys_reset = (state != RUN)
  - wiz_resetn = (state != WIZ_RST)
  - ready = (state == RUN)
  - All outputs are registered (decoded from registered next-state), so they are glitch-free.

## Timing
- Reset values: state=WIZ_RST, wiz_resetn=0, sys_reset=1, ready=0, relock_count=0, lock_timeout=0, synchronizer flops=0.
- Reset asserted mid-operation returns everything to the reset values on the next edge. Counts and the sticky flag are cleared.
- First wiz_resetn rise: WIZ_RST_CYCLES edges after the first edge with reset=0.
- Lock latency: let edge E be the first edge at which locked_in=1 is captured by sync flop 1. The FSM enters STABLE at E+2.
- sys_reset falls and ready rises at edge E+2+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES, provided lock is uninterrupted.
- Lock loss in RUN: sys_reset=1 and wiz_resetn=0 at the edge 3 cycles after locked_in falls (2 sync + 1 register).
- Soft reset: sys_reset is high for exactly RST_HOLD_CYCLES cycles, starting the edge after the request.

## Configuration
- RST_SEQ_TIMEOUT_EN defined:
  - WAIT_LOCK uses the LOCK_TIMEOUT_CYCLES counter. Timeout restarts the wizard and sets lock_timeout.
  - lock_timeout clears only on reset.
- RST_SEQ_TIMEOUT_EN undefined:
  - WAIT_LOCK waits indefinitely.
  - lock_timeout is tied to 0.
  - The timeout logic is absent.

## Structure
- rst_seq_pkg holds:
  - the state enum rst_seq_state_e;
  - the relock_count width constant (8);
  - a function sizing the shared counter from the maximum of the cycle parameters.
- One sub-module, sync_2ff: a generic 2-flop synchronizer with a synchronous-reset value of 0, used for locked_in.

## Test plan
Directed scenarios, all with WIZ_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32.
- Cold start: release reset at edge 0 and raise locked_in before edge 10.
  - wiz_resetn rises at edge 4.
  - sys_reset falls and ready rises at edge 24.
- Glitch during STABLE: drop locked_in for 1 cycle after 5 stable cycles.
  - sys_reset stays 1.
  - The full 8-cycle window restarts after relock.
  - relock_count stays 0.
- Lock loss in RUN: drop locked_in.
  - sys_reset=1 and wiz_resetn=0 three edges later.
  - wiz_resetn is low for 4 cycles.
  - relock_count=1.
- Soft reset and lock loss in the same RUN cycle: lock-loss path is taken and relock_count increments.
- Soft reset alone in RUN:
  - sys_reset is high for exactly 4 cycles.
  - wiz_resetn stays 1.
  - relock_count is unchanged.
- Timeout (RST_SEQ_TIMEOUT_EN defined): hold locked_in=0.
  - After 32 WAIT_LOCK cycles, lock_timeout=1 and wiz_resetn pulses low for 4 cycles.
  - A mid-sequence reset clears lock_timeout and relock_count.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the FPGA reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WIZ_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } rst_seq_state_e;

    localparam int unsigned RELOCK_CNT_W = 8;

    // Width of the shared down-counter: must hold the largest cycle parameter.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer; both stages clear to 0 on synchronous reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: restarts the clock wizard, qualifies its lock and releases sys_reset.
// Optional wait-for-lock timeout is built in when RST_SEQ_TIMEOUT_EN is defined.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned WIZ_RST_CYCLES      = 8,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    locked_in,
    input  logic                    soft_rst_req,
    output logic                    wiz_resetn,
    output logic                    sys_reset,
    output logic                    ready,
    output logic [RELOCK_CNT_W-1:0] relock_count,
    output logic                    lock_timeout
);

    localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES,
                                              WIZ_RST_CYCLES, LOCK_TIMEOUT_CYCLES);

    // Entry loads are N-1 so a state lasts exactly N cycles (exit on counter==0).
    // Out of reset the first edge already counts, so the wizard load is one larger.
    localparam logic [CNT_W-1:0] WIZ_INIT    = CNT_W'(WIZ_RST_CYCLES);
    localparam logic [CNT_W-1:0] WIZ_LOAD    = CNT_W'(WIZ_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [RELOCK_CNT_W-1:0] RELOCK_MAX = '1;

    logic                    locked_s;
    rst_seq_state_e          state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
    logic                    wiz_resetn_q;
    logic                    sys_reset_q;
    logic                    ready_q;
    logic                    cnt_zero;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (locked_in),
        .q_o   (locked_s)
    );

    assign cnt_zero = (cnt_q == '0);

`ifdef RST_SEQ_TIMEOUT_EN
    logic tmo_q, tmo_d;
`endif

    // Next-state, counter and relock bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;
`ifdef RST_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            ST_WIZ_RST: begin
                if (cnt_zero) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = STABLE_LOAD;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                else if (cnt_zero) begin
                    state_d = ST_WIZ_RST;
                    cnt_d   = WIZ_LOAD;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            ST_STABLE: begin
                // Any dropout forfeits the whole stability window.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = WAIT_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WIZ_RST;
                    cnt_d   = WIZ_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss outranks a simultaneous soft reset request.
                if (!locked_s) begin
                    state_d = ST_WIZ_RST;
                    cnt_d   = WIZ_LOAD;
                    if (relock_q != RELOCK_MAX) begin
                        relock_d = relock_q + RELOCK_CNT_W'(1);
                    end
                end else if (soft_rst_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            default: begin
                state_d = ST_WIZ_RST;
                cnt_d   = WIZ_LOAD;
            end
        endcase
    end

    // State and outputs; outputs decode the next state so they change with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_WIZ_RST;
            cnt_q        <= WIZ_INIT;
            relock_q     <= '0;
            wiz_resetn_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            relock_q     <= relock_d;
            wiz_resetn_q <= (state_d != ST_WIZ_RST);
            sys_reset_q  <= (state_d != ST_RUN);
            ready_q      <= (state_d == ST_RUN);
`ifdef RST_SEQ_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign wiz_resetn   = wiz_resetn_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign lock_timeout = tmo_q;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed scoreboard bench for rst_seq_ctrl: expectations are queued per edge as stimulus is driven.
module tb_rst_seq_ctrl;

    localparam int unsigned WIZ_N  = 4;
    localparam int unsigned STB_N  = 8;
    localparam int unsigned HOLD_N = 4;
    localparam int unsigned TMO_N  = 32;

    localparam int S_WIZ = 0;
    localparam int S_SYS = 1;
    localparam int S_RDY = 2;
    localparam int S_RLK = 3;
    localparam int S_TMO = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked_in;
    logic       soft_rst_req;
    logic       wiz_resetn;
    logic       sys_reset;
    logic       ready;
    logic [7:0] relock_count;
    logic       lock_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int base     = 0;

    typedef struct {
        int    at;
        int    sel;
        int    val;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t keep_q[$];

    rst_seq_ctrl #(
        .LOCK_STABLE_CYCLES  (STB_N),
        .RST_HOLD_CYCLES     (HOLD_N),
        .WIZ_RST_CYCLES      (WIZ_N),
        .LOCK_TIMEOUT_CYCLES (TMO_N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .locked_in    (locked_in),
        .soft_rst_req (soft_rst_req),
        .wiz_resetn   (wiz_resetn),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .relock_count (relock_count),
        .lock_timeout (lock_timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            S_WIZ:   return int'(wiz_resetn);
            S_SYS:   return int'(sys_reset);
            S_RDY:   return int'(ready);
            S_RLK:   return int'(relock_count);
            default: return int'(lock_timeout);
        endcase
    endfunction

    task automatic push_abs(input int at, input int sel, input int val, input string tag);
        exp_t e;
        e.at  = at;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic push(input int e, input int sel, input int val, input string tag);
        push_abs(base + e, sel, val, tag);
    endtask

    // Compare every expectation due at the edge just passed.
    always @(negedge clock) begin
        keep_q.delete();
        foreach (sb_q[i]) begin
            if (sb_q[i].at == edge_cnt) check_val(sb_q[i].tag, obs(sb_q[i].sel), sb_q[i].val);
            else keep_q.push_back(sb_q[i]);
        end
        sb_q = keep_q;
    end

    task automatic wait_rel(input int e);
        while (edge_cnt < base + e) @(negedge clock);
    endtask

    task automatic mark();
        base = edge_cnt;
    endtask

    // Asserts reset for three edges; afterwards base is the first edge with reset low.
    task automatic apply_reset(input string tag);
        reset        = 1'b1;
        soft_rst_req = 1'b0;
        push_abs(edge_cnt + 1, S_WIZ, 0, {tag, "_wiz"});
        push_abs(edge_cnt + 1, S_SYS, 1, {tag, "_sys"});
        push_abs(edge_cnt + 1, S_RDY, 0, {tag, "_rdy"});
        push_abs(edge_cnt + 1, S_RLK, 0, {tag, "_rlk"});
        push_abs(edge_cnt + 1, S_TMO, 0, {tag, "_tmo"});
        repeat (3) @(negedge clock);
        reset = 1'b0;
        base  = edge_cnt + 1;
    endtask

    initial begin
        reset        = 1'b1;
        locked_in    = 1'b0;
        soft_rst_req = 1'b0;
        apply_reset("por");

        // Cold start: lock captured at edge 10, release at 10+2+8+4.
        push(3,  S_WIZ, 0, "cold_wiz_lo");
        push(4,  S_WIZ, 1, "cold_wiz_rise");
        push(23, S_SYS, 1, "cold_sys_pre");
        push(24, S_SYS, 0, "cold_sys_rel");
        push(23, S_RDY, 0, "cold_rdy_pre");
        push(24, S_RDY, 1, "cold_rdy");
        push(24, S_RLK, 0, "cold_rlk");
        wait_rel(9);
        locked_in = 1'b1;
        wait_rel(26);

        // Lock loss in RUN, then a one-cycle glitch during the relock window.
        mark();
        locked_in = 1'b0;
        push(2,  S_SYS, 0, "loss_sys_pre");
        push(2,  S_WIZ, 1, "loss_wiz_pre");
        push(3,  S_SYS, 1, "loss_sys");
        push(3,  S_WIZ, 0, "loss_wiz");
        push(3,  S_RDY, 0, "loss_rdy");
        push(3,  S_RLK, 1, "loss_rlk");
        push(6,  S_WIZ, 0, "loss_wiz_end");
        push(7,  S_WIZ, 1, "loss_wiz_rise");
        push(20, S_WIZ, 1, "glitch_wiz");
        push(25, S_SYS, 1, "glitch_no_credit");
        push(32, S_SYS, 1, "glitch_sys_pre");
        push(33, S_SYS, 0, "glitch_release");
        push(33, S_RDY, 1, "glitch_rdy");
        push(33, S_RLK, 1, "glitch_rlk");
        wait_rel(10);
        locked_in = 1'b1;
        wait_rel(17);
        locked_in = 1'b0;
        wait_rel(18);
        locked_in = 1'b1;
        wait_rel(35);

        // Soft reset alone; a second request while in HOLD must be ignored.
        mark();
        soft_rst_req = 1'b1;
        push(1, S_SYS, 1, "soft_sys_on");
        push(4, S_SYS, 1, "soft_sys_last");
        push(5, S_SYS, 0, "soft_sys_off");
        push(1, S_RDY, 0, "soft_rdy_off");
        push(5, S_RDY, 1, "soft_rdy_on");
        push(3, S_WIZ, 1, "soft_wiz");
        push(5, S_RLK, 1, "soft_rlk");
        wait_rel(1);
        soft_rst_req = 1'b0;
        wait_rel(2);
        soft_rst_req = 1'b1;
        wait_rel(3);
        soft_rst_req = 1'b0;
        wait_rel(7);

        // Soft request and synchronized lock loss on the same RUN edge.
        mark();
        locked_in = 1'b0;
        push(3,  S_WIZ, 0, "both_wiz");
        push(3,  S_SYS, 1, "both_sys");
        push(3,  S_RLK, 2, "both_rlk");
        push(7,  S_WIZ, 1, "both_wiz_rise");
        push(21, S_RDY, 0, "both_rdy_pre");
        push(22, S_RDY, 1, "both_rdy");
        wait_rel(2);
        soft_rst_req = 1'b1;
        wait_rel(3);
        soft_rst_req = 1'b0;
        wait_rel(7);
        locked_in = 1'b1;
        wait_rel(24);

        // Lock loss during HOLD restarts the wizard without counting a relock.
        mark();
        soft_rst_req = 1'b1;
        push(3, S_WIZ, 1, "hold_wiz_pre");
        push(4, S_WIZ, 0, "hold_loss_wiz");
        push(4, S_SYS, 1, "hold_loss_sys");
        push(5, S_RLK, 2, "hold_rlk");
        wait_rel(1);
        soft_rst_req = 1'b0;
        locked_in    = 1'b0;
        wait_rel(6);

        // Mid-sequence reset clears the relock count; then no lock ever arrives.
        apply_reset("mid");
        push(35, S_WIZ, 1, "wait_wiz_pre");
        push(35, S_TMO, 0, "wait_tmo_pre");
`ifdef RST_SEQ_TIMEOUT_EN
        push(36, S_TMO, 1, "tmo_set");
        push(36, S_WIZ, 0, "tmo_wiz");
        push(39, S_WIZ, 0, "tmo_wiz_end");
        push(40, S_WIZ, 1, "tmo_wiz_rise");
        push(40, S_TMO, 1, "tmo_sticky");
`else
        push(36, S_WIZ, 1, "wait_forever");
        push(36, S_TMO, 0, "tmo_tied");
        push(40, S_SYS, 1, "wait_sys");
`endif
        wait_rel(41);
        apply_reset("tmo_clr");
        wait_rel(2);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clock);
        if (sb_q.size() != 0) check_val("sb_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
